debug_bp_unit: RTL
==================

Name: debug_bp_unit

Overview:
- Parametrised breakpoint and trap-collection unit for the write stage.
- Generalises the fixed 4-channel debug logic to NUM_BP channels and a configurable linear-address width. Length encodings go up to 8 bytes.
- Adds a 2-stage pipelined data-address compare and an explicit finish/ack handshake toward the exception logic.
- Collects code, data-read, data-write, single-step and task-switch debug conditions per instruction. Raises one prepare pulse per instruction, then holds the status until it is acknowledged.

Parameters:
- NUM_BP, 4, number of breakpoint channels (1..8)
- AW, 32, linear address width
- CNT_W, 8, hit-counter width (used only with the optional feature)

Ports:
- clk  in  1  clock; one clock domain only
- rst  in  1  reset; synchronous, active-high
- bp_addr  in  NUM_BP*AW  breakpoint linear addresses, channel i at [i*AW +: AW]
- bp_len  in  2*NUM_BP  length encoding: 00=1, 01=2, 11=4, 10=8 bytes
- bp_rw  in  2*NUM_BP  00=exec, 01=write, 10=reserved (never matches), 11=read/write
- bp_en  in  2*NUM_BP  local/global enable pair; channel is active if either bit is set
- acc_valid  in  1  data access beat
- acc_addr  in  AW  first byte of the access
- acc_size  in  4  byte count, 1..8; 0 is treated as 1
- acc_write  in  1  1=write, 0=read
- code_addr  in  AW  linear address of the next instruction
- code_ok  in  1  code address is within the segment limit
- rflag  in  1  RF set; suppresses code breakpoints
- tflag  in  1  TF value at commit
- string_busy  in  1  string iteration in progress; suppresses code breakpoints
- task_trig  in  1  T-bit task switch occurred this instruction
- inhibit  in  1  inhibit interrupts and debug
- trap_clear  in  1  clear accumulated data hits and pending step
- instr_finished  in  1  instruction commit request
- finish_ready  out  1  compare pipeline empty; commit may be accepted
- debug_prepare  out  1  one-cycle pulse on a debug-causing commit
- stat_code  out  NUM_BP  latched code hits
- stat_data  out  NUM_BP  latched read/write hits
- stat_step  out  1  latched single-step condition
- stat_task  out  1  latched task-switch condition
- stat_valid  out  1  status held and awaiting ack
- stat_ack  in  1  consumer accepts the status

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, pipeline flushed, state IDLE, accumulators cleared. Applies in any state, mid-operation included.
- Byte mask per channel: m = {1, len==01|len==11|len==10 for bit1... }, i.e. the low 3 bits are masked to 0 for an 8-byte length, 2 bits for 4, 1 bit for 2, none for 1.
- Breakpoint range per channel: lo = addr & ~m, hi = addr | m.
- Data stage P1: register acc_addr, the last byte (acc_addr + size - 1, modulo 2^AW, wrap allowed) and acc_write.
- Data stage P2: match[i] = bp_en[i]!=0 & rw in {01 (write only), 11} & P1.first <= hi & P1.last >= lo.
  - A read matches only on rw==11.
  - A write matches on rw==01 or rw==11.
- Data hits are OR-accumulated into acc_data; total latency 2 cycles from acc_valid.
- finish_ready = no valid entry in P1 or P2.
- Code hits are computed combinationally at commit. A code hit on channel i needs rw==00, bp_en!=0, code_ok, !rflag, !string_busy, and masked code_addr == masked bp_addr.
- Step accumulator:
  - set to tflag on each accepted commit;
  - cleared by trap_clear;
  - the value used at a commit is the one set by the previous instruction.
- State machine IDLE/HOLD:
  - Commit accepted when instr_finished & finish_ready & state==IDLE.
  - instr_finished while not ready: the commit is ignored. The driver must hold instr_finished.
  - On accept with !inhibit and (task_trig | step | any code hit | acc_data!=0): debug_prepare=1 for one cycle, all stat_* latched, stat_valid=1, go to HOLD.
  - On accept otherwise: clear acc_data, stay IDLE.
  - With inhibit=1: accumulators are kept unchanged, including any hits from this instruction.
- HOLD:
  - new accesses still enter the pipeline and accumulate;
  - commits are stalled (finish_ready forced 0);
  - stat_ack → IDLE, stat_valid=0, and acc_data/step are cleared in the same cycle.
- Precedence:
  - rst > trap_clear > commit > accumulate.
  - trap_clear and acc_valid in the same cycle: the in-flight hit still lands 2 cycles later.

Optional Feature:
- Macro DEBUG_BP_HITCNT_EN.
- Defined:
  - per-channel saturating CNT_W counters increment on each code or data hit that reaches stat_*;
  - output hit_cnt (NUM_BP*CNT_W);
  - input hit_cnt_clr clears all counters;
  - counters are reset to 0.
- Not defined: no counters, no extra ports; behaviour otherwise identical.

Decomposition:
- Package debug_bp_pkg holds:
  - length and RW encodings;
  - the mask function;
  - state enum IDLE/HOLD.
- Natural sub-module: debug_bp_channel, instantiated NUM_BP times; it does the range and code compare for one channel.

Test Plan:
- bp0 = 0x1004, len=11, rw=01: 2-byte write at 0x1006 → match; commit with stat_data=0001, debug_prepare pulse 2+ cycles after the access.
- Same channel, 1-byte read at 0x1006 → no hit; set rw=11 and repeat → stat_data=0001.
- bp2 = 0x2000, rw=00; commit with code_addr=0x2000 and rflag=0 → stat_code=0100. Same with rflag=1 → no prepare.
- tflag=1 on commit N, then commit N+1 → stat_step=1 on N+1. trap_clear between the two → no prepare.
- Write to 0xFFFFFFFE with size 4 (wraps) against bp at 0xFFFFFFFF len=00 → hit. Assert rst in HOLD → all outputs 0 the next cycle.
- Hit then commit with inhibit=1 → no pulse, hit retained; next commit with inhibit=0 → prepare. Hold stat_ack low 5 cycles → stat_valid stays high and finish_ready stays 0.

Source files
------------

// File: rtl/debug_bp_pkg.sv
// Shared encodings, state type and length-mask helper for the debug breakpoint unit.
package debug_bp_pkg;

    localparam logic [1:0] LEN_1 = 2'b00;
    localparam logic [1:0] LEN_2 = 2'b01;
    localparam logic [1:0] LEN_8 = 2'b10;
    localparam logic [1:0] LEN_4 = 2'b11;

    localparam logic [1:0] RW_EXEC  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_RSVD  = 2'b10;
    localparam logic [1:0] RW_RDWR  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Low address bits ignored by a breakpoint of the given length.
    function automatic logic [2:0] len_mask(input logic [1:0] len);
        case (len)
            LEN_2:   len_mask = 3'b001;
            LEN_4:   len_mask = 3'b011;
            LEN_8:   len_mask = 3'b111;
            default: len_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/debug_bp_channel.sv
// One breakpoint channel: data-range overlap and code-address compare.
module debug_bp_channel
    import debug_bp_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] bp_addr,
    input  logic [1:0]    bp_len,
    input  logic [1:0]    bp_rw,
    input  logic [1:0]    bp_en,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    input  logic          write,
    input  logic [AW-1:0] code_addr,
    output logic          data_match,
    output logic          code_match
);

    logic [AW-1:0] mask;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic          rw_ok;
    logic          overlap;

    always_comb begin
        mask      = '0;
        mask[2:0] = len_mask(bp_len);
        lo        = bp_addr & ~mask;
        hi        = bp_addr | mask;
        rw_ok     = (bp_rw == RW_RDWR) || ((bp_rw == RW_WRITE) && write);
        // A wrapped access covers [first, max] plus [0, last].
        if (last < first)
            overlap = (first <= hi) || (last >= lo);
        else
            overlap = (first <= hi) && (last >= lo);
        data_match = (|bp_en) && rw_ok && overlap;
        code_match = (|bp_en) && (bp_rw == RW_EXEC) && ((code_addr & ~mask) == lo);
    end

endmodule

// File: rtl/debug_bp_unit.sv
// Breakpoint and debug-trap collection unit for the write stage.
// Optional per-channel hit counters are enabled with DEBUG_BP_HITCNT_EN.
module debug_bp_unit
    import debug_bp_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int AW     = 32,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BP*AW-1:0]    bp_addr,
    input  logic [2*NUM_BP-1:0]     bp_len,
    input  logic [2*NUM_BP-1:0]     bp_rw,
    input  logic [2*NUM_BP-1:0]     bp_en,
    input  logic                    acc_valid,
    input  logic [AW-1:0]           acc_addr,
    input  logic [3:0]              acc_size,
    input  logic                    acc_write,
    input  logic [AW-1:0]           code_addr,
    input  logic                    code_ok,
    input  logic                    rflag,
    input  logic                    tflag,
    input  logic                    string_busy,
    input  logic                    task_trig,
    input  logic                    inhibit,
    input  logic                    trap_clear,
    input  logic                    instr_finished,
    output logic                    finish_ready,
    output logic                    debug_prepare,
    output logic [NUM_BP-1:0]       stat_code,
    output logic [NUM_BP-1:0]       stat_data,
    output logic                    stat_step,
    output logic                    stat_task,
    output logic                    stat_valid,
`ifdef DEBUG_BP_HITCNT_EN
    input  logic                    hit_cnt_clr,
    output logic [NUM_BP*CNT_W-1:0] hit_cnt,
`endif
    input  logic                    stat_ack
);

    logic [AW-1:0]     first_p1;
    logic [AW-1:0]     last_p1;
    logic              write_p1;
    logic              vld_p1;
    logic [NUM_BP-1:0] hit_p2;
    logic              vld_p2;

    logic [NUM_BP-1:0] match;
    logic [NUM_BP-1:0] code_raw;
    logic [NUM_BP-1:0] code_hit;
    logic [NUM_BP-1:0] acc_data;
    logic              step;
    state_t            state;

    logic [AW-1:0]     size_ext;
    logic [AW-1:0]     last_c;
    logic              accept;
    logic              cause;
    logic              fire;

    always_comb begin
        size_ext = (acc_size == 4'd0) ? AW'(1) : AW'(acc_size);
        last_c   = acc_addr + size_ext - AW'(1);
        code_hit = (code_ok && !rflag && !string_busy) ? code_raw : '0;
        accept   = instr_finished && finish_ready && (state == IDLE);
        cause    = task_trig || step || (|code_hit) || (|acc_data);
        fire     = accept && !inhibit && cause;
    end

    for (genvar i = 0; i < NUM_BP; i++) begin : g_ch
        debug_bp_channel #(.AW(AW)) u_ch (
            .bp_addr    (bp_addr[i*AW +: AW]),
            .bp_len     (bp_len[2*i +: 2]),
            .bp_rw      (bp_rw[2*i +: 2]),
            .bp_en      (bp_en[2*i +: 2]),
            .first      (first_p1),
            .last       (last_p1),
            .write      (write_p1),
            .code_addr  (code_addr),
            .data_match (match[i]),
            .code_match (code_raw[i])
        );
    end

    // P1 captures the access span, P2 captures the per-channel compare result
    always_ff @(posedge clk) begin
        first_p1 <= acc_addr;
        last_p1  <= last_c;
        write_p1 <= acc_write;
        hit_p2   <= match;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= acc_valid;
            vld_p2 <= vld_p1;
        end
    end

    // Commit / hold state machine and the trap accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc_data      <= '0;
            step          <= 1'b0;
            finish_ready  <= 1'b0;
            debug_prepare <= 1'b0;
            stat_code     <= '0;
            stat_data     <= '0;
            stat_step     <= 1'b0;
            stat_task     <= 1'b0;
            stat_valid    <= 1'b0;
        end else begin
            debug_prepare <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        debug_prepare <= 1'b1;
                        stat_code     <= code_hit;
                        stat_data     <= acc_data;
                        stat_step     <= step;
                        stat_task     <= task_trig;
                        stat_valid    <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (stat_ack) begin
                        stat_code  <= '0;
                        stat_data  <= '0;
                        stat_step  <= 1'b0;
                        stat_task  <= 1'b0;
                        stat_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (trap_clear || ((state == HOLD) && stat_ack)) begin
                acc_data <= '0;
                step     <= 1'b0;
            end else if (accept && !inhibit) begin
                step <= tflag;
                if (!cause)
                    acc_data <= '0;
            end else if (vld_p2) begin
                acc_data <= acc_data | hit_p2;
            end

            // Ready next cycle only if nothing will sit in P1/P2 and we stay idle.
            finish_ready <= !acc_valid && !vld_p1 &&
                            ((state == IDLE) ? !fire : stat_ack);
        end
    end

`ifdef DEBUG_BP_HITCNT_EN
    logic [CNT_W-1:0] cnt [NUM_BP];

    always_ff @(posedge clk) begin
        if (rst || hit_cnt_clr) begin
            for (int i = 0; i < NUM_BP; i++)
                cnt[i] <= '0;
        end else if (fire) begin
            for (int i = 0; i < NUM_BP; i++)
                if ((code_hit[i] || acc_data[i]) && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BP; i++) begin : g_cnt
        assign hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`else
    // CNT_W only sizes the optional hit counters.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
